// File: rtl/branch_resolve_pkg.sv
// Shared types and constants for the branch resolution unit.
package branch_resolve_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

    localparam int PC_WIDTH_DEF = 32;
    localparam int INSN_BYTES   = 4;

endpackage

// File: rtl/branch_resolve_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        inc_en,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_en && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_resolve.sv
// Resolves branches in EX: trains the predictor, redirects fetch on a
// mispredict and holds flush for a fixed number of enabled cycles.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_WIDTH     = PC_WIDTH_DEF
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                ex_valid,
    input  logic                ex_is_br,
    input  logic                ex_taken,
    input  logic [PC_WIDTH-1:0] ex_pc,
    input  logic [PC_WIDTH-1:0] ex_target_pc,
    input  logic                ex_pred_taken,
    input  logic [PC_WIDTH-1:0] ex_pred_pc,
    output logic                upd_valid,
    output logic [PC_WIDTH-1:0] upd_pc,
    output logic [PC_WIDTH-1:0] upd_target,
    output logic                upd_taken,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                flush,
    output logic [31:0]         br_count,
    output logic [31:0]         mispred_count
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    br_state_e           state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                upd_valid_q, upd_valid_d;
    logic [PC_WIDTH-1:0] upd_pc_q, upd_pc_d;
    logic [PC_WIDTH-1:0] upd_target_q, upd_target_d;
    logic                upd_taken_q, upd_taken_d;
    logic                redirect_valid_q, redirect_valid_d;
    logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    logic                accept;
    logic                mispred;
    logic [PC_WIDTH-1:0] corr_pc;

    // Branches seen while flushing are on the wrong path and must be dropped.
    assign accept  = rdy_in & ex_valid & ex_is_br & (state_q == IDLE);
    assign mispred = (ex_taken != ex_pred_taken) |
                     (ex_taken & ex_pred_taken & (ex_target_pc != ex_pred_pc));
    assign corr_pc = ex_taken ? ex_target_pc : (ex_pc + PC_WIDTH'(INSN_BYTES));

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        upd_valid_d      = upd_valid_q;
        upd_pc_d         = upd_pc_q;
        upd_target_d     = upd_target_q;
        upd_taken_d      = upd_taken_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;

        // With rdy_in low everything above simply holds, strobes included.
        if (rdy_in) begin
            upd_valid_d      = 1'b0;
            redirect_valid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        upd_valid_d  = 1'b1;
                        upd_pc_d     = ex_pc;
                        upd_target_d = ex_target_pc;
                        upd_taken_d  = ex_taken;
                        if (mispred) begin
                            redirect_valid_d = 1'b1;
                            redirect_pc_d    = corr_pc;
                            state_d          = FLUSH;
                            cnt_d            = FLUSH_LOAD;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q          <= IDLE;
            cnt_q            <= 4'd0;
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_target_q     <= '0;
            upd_taken_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            upd_valid_q      <= upd_valid_d;
            upd_pc_q         <= upd_pc_d;
            upd_target_q     <= upd_target_d;
            upd_taken_q      <= upd_taken_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    sat_counter32 u_br_count (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .inc_en (accept),
        .count  (br_count)
    );

    sat_counter32 u_mispred_count (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .inc_en (accept & mispred),
        .count  (mispred_count)
    );

    assign upd_valid      = upd_valid_q;
    assign upd_pc         = upd_pc_q;
    assign upd_target     = upd_target_q;
    assign upd_taken      = upd_taken_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = (state_q == FLUSH);

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with FLUSH_CYCLES=2, PC_WIDTH=32.
module tb_branch_resolve;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        ex_valid, ex_is_br, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target_pc, ex_pred_pc;
    logic        upd_valid, upd_taken, redirect_valid, flush;
    logic [31:0] upd_pc, upd_target, redirect_pc, br_count, mispred_count;

    int n_checks = 0;
    int n_fails  = 0;

    branch_resolve #(.FLUSH_CYCLES(2), .PC_WIDTH(32)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_taken       (ex_taken),
        .ex_pc          (ex_pc),
        .ex_target_pc   (ex_target_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_pc     (ex_pred_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ppc);
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_taken = tk;
        ex_pc = pc; ex_target_pc = tgt; ex_pred_taken = ptk; ex_pred_pc = ppc;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0; ex_is_br = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
        ex_pc = '0; ex_target_pc = '0; ex_pred_pc = '0;
    endtask

    task automatic chk_strobes(input string tag, input logic uv, input logic rv, input logic fl);
        chk({tag, "_upd_valid"}, 32'(upd_valid), 32'(uv));
        chk({tag, "_redirect_valid"}, 32'(redirect_valid), 32'(rv));
        chk({tag, "_flush"}, 32'(flush), 32'(fl));
    endtask

    task automatic chk_counts(input string tag, input logic [31:0] b, input logic [31:0] m);
        chk({tag, "_br_count"}, br_count, b);
        chk({tag, "_mispred_count"}, mispred_count, m);
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        idle_ex();
        tick(); tick();
        chk_strobes("reset", 1'b0, 1'b0, 1'b0);
        chk_counts("reset", 32'd0, 32'd0);
        chk("reset_upd_pc", upd_pc, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        rst_in = 1'b1;
        tick();
        $display("step reset done");

        // Correctly predicted taken branch
        present(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        tick();
        idle_ex();
        chk_strobes("correct", 1'b1, 1'b0, 1'b0);
        chk("correct_upd_pc", upd_pc, 32'h100);
        chk("correct_upd_target", upd_target, 32'h200);
        chk("correct_upd_taken", 32'(upd_taken), 32'd1);
        chk_counts("correct", 32'd1, 32'd0);
        tick();
        chk_strobes("correct_after", 1'b0, 1'b0, 1'b0);
        $display("step correct predict done");

        // Back-to-back correct predictions
        present(32'h300, 1'b1, 32'h380, 1'b1, 32'h380);
        tick();
        chk("b2b_first_upd_valid", 32'(upd_valid), 32'd1);
        chk("b2b_first_upd_pc", upd_pc, 32'h300);
        present(32'h304, 1'b0, 32'h999, 1'b0, 32'h0);
        tick();
        idle_ex();
        chk_strobes("b2b_second", 1'b1, 1'b0, 1'b0);
        chk("b2b_second_upd_pc", upd_pc, 32'h304);
        chk("b2b_second_upd_taken", 32'(upd_taken), 32'd0);
        chk_counts("b2b", 32'd3, 32'd0);
        tick();
        $display("step back-to-back done");

        // Non-branch with mismatching direction fields
        present(32'h400, 1'b1, 32'h500, 1'b0, 32'h0);
        ex_is_br = 1'b0;
        tick();
        idle_ex();
        chk_strobes("nonbr", 1'b0, 1'b0, 1'b0);
        chk_counts("nonbr", 32'd3, 32'd0);
        $display("step non-branch done");

        // Direction mispredict
        present(32'h104, 1'b0, 32'h700, 1'b1, 32'h700);
        tick();
        idle_ex();
        chk_strobes("dir_mp", 1'b1, 1'b1, 1'b1);
        chk("dir_mp_redirect_pc", redirect_pc, 32'h108);
        chk_counts("dir_mp", 32'd4, 32'd1);
        tick();
        chk_strobes("dir_mp_c2", 1'b0, 1'b0, 1'b1);
        tick();
        chk_strobes("dir_mp_c3", 1'b0, 1'b0, 1'b0);
        $display("step direction mispredict done");

        // Target mispredict, then a wrong-path branch during flush
        present(32'h10, 1'b1, 32'h80, 1'b1, 32'h40);
        tick();
        chk_strobes("tgt_mp", 1'b1, 1'b1, 1'b1);
        chk("tgt_mp_redirect_pc", redirect_pc, 32'h80);
        chk_counts("tgt_mp", 32'd5, 32'd2);
        present(32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
        tick();
        idle_ex();
        chk_strobes("wrong_path", 1'b0, 1'b0, 1'b1);
        chk_counts("wrong_path", 32'd5, 32'd2);
        tick();
        chk_strobes("tgt_mp_end", 1'b0, 1'b0, 1'b0);
        $display("step target mispredict + wrong path done");

        // PC wrap and rdy stall mid-flush
        present(32'hFFFF_FFFC, 1'b0, 32'h1234, 1'b1, 32'h1234);
        tick();
        idle_ex();
        chk_strobes("wrap", 1'b1, 1'b1, 1'b1);
        chk("wrap_redirect_pc", redirect_pc, 32'h0);
        chk_counts("wrap", 32'd6, 32'd3);
        rdy_in = 1'b0;
        present(32'h20, 1'b1, 32'h30, 1'b1, 32'h30);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_strobes($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b1);
            chk_counts($sformatf("stall%0d", i), 32'd6, 32'd3);
        end
        idle_ex();
        rdy_in = 1'b1;
        tick();
        chk_strobes("stall_resume", 1'b0, 1'b0, 1'b1);
        tick();
        chk_strobes("stall_end", 1'b0, 1'b0, 1'b0);
        chk_counts("stall_end", 32'd6, 32'd3);
        $display("step wrap + stall done");

        // Reset on the first flush cycle
        present(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
        tick();
        idle_ex();
        chk("rstmid_flush_pre", 32'(flush), 32'd1);
        rst_in = 1'b0;
        #1;
        chk_strobes("rstmid", 1'b0, 1'b0, 1'b0);
        chk_counts("rstmid", 32'd0, 32'd0);
        chk("rstmid_redirect_pc", redirect_pc, 32'd0);
        #2;
        rst_in = 1'b1;
        tick();
        chk_strobes("rstmid_after", 1'b0, 1'b0, 1'b0);
        tick();
        chk_strobes("rstmid_after2", 1'b0, 1'b0, 1'b0);
        present(32'h40, 1'b1, 32'h60, 1'b1, 32'h60);
        tick();
        idle_ex();
        chk_strobes("rstmid_idle", 1'b1, 1'b0, 1'b0);
        chk_counts("rstmid_idle", 32'd1, 32'd0);
        $display("step reset mid-flush done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning cycles flush stays high after a mispredict (legal 1..15).
REQ-002 SHALL have parameter PC_WIDTH, default 32, meaning the width of every PC/target port.
REQ-003 SHALL have port clk_in  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-006 SHALL have port ex_valid  input  1  EX stage holds a resolved instruction this cycle.
REQ-007 SHALL have port ex_is_br  input  1  that instruction is a branch or jump.
REQ-008 SHALL have port ex_taken  input  1  actual direction.
REQ-009 SHALL have port ex_pc  input  PC_WIDTH  instruction PC.
REQ-010 SHALL have port ex_target_pc  input  PC_WIDTH  actual taken target.
REQ-011 SHALL have port ex_pred_taken  input  1  direction predicted at fetch.
REQ-012 SHALL have port ex_pred_pc  input  PC_WIDTH  target predicted at fetch.
REQ-013 SHALL have port upd_valid  output  1  one-cycle predictor update strobe.
REQ-014 SHALL have ports upd_pc, upd_target  output  PC_WIDTH, and upd_taken  output  1: update payload to the predictor.
REQ-015 SHALL have port redirect_valid  output  1  one-cycle fetch redirect strobe.
REQ-016 SHALL have port redirect_pc  output  PC_WIDTH  corrected fetch PC.
REQ-017 SHALL have port flush  output  1  squash younger pipeline stages.
REQ-018 SHALL have ports br_count, mispred_count  output  32  resolved-branch and mispredict counters.

Function
REQ-019 A branch SHALL be accepted when rdy_in & ex_valid & ex_is_br & state==IDLE; all other ex_* cycles SHALL be ignored.
REQ-020 Mispredict SHALL be (ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target_pc != ex_pred_pc).
REQ-021 Corrected PC SHALL be ex_taken ? ex_target_pc : ex_pc + 4, wrapping modulo 2^PC_WIDTH.
REQ-022 Every accepted branch SHALL produce upd_valid=1 exactly one cycle later with upd_pc=ex_pc, upd_target=ex_target_pc, upd_taken=ex_taken, whether or not it mispredicted.
REQ-023 An accepted mispredict SHALL, one cycle later, raise redirect_valid for one cycle with redirect_pc=corrected PC and enter state FLUSH.
REQ-024 States SHALL be IDLE and FLUSH; in FLUSH, flush=1 and a down-counter loaded with FLUSH_CYCLES-1 decrements each enabled cycle; at zero, return to IDLE with flush=0 on the following cycle.
REQ-025 flush SHALL be high for exactly FLUSH_CYCLES enabled cycles, first cycle coincident with redirect_valid.
REQ-026 ex_valid branches arriving during FLUSH SHALL be wrong-path: no update, no redirect, no count.
REQ-027 br_count SHALL increment per accepted branch, mispred_count per accepted mispredict; both saturate at 32'hFFFFFFFF.
REQ-028 Back-to-back correctly predicted branches in IDLE SHALL each produce an update on consecutive cycles.
REQ-029 rdy_in=0 SHALL hold state, counters and all outputs; strobes held high SHALL not re-issue when rdy_in returns (they clear on the next enabled cycle).
REQ-030 Non-branch ex_valid cycles SHALL produce no outputs.

Reset
REQ-031 rst_in low SHALL asynchronously force state=IDLE, flush counter=0, and all outputs to 0 (upd_*, redirect_*, flush, both counters).
REQ-032 Reset asserted during FLUSH SHALL abort it immediately; no redirect or update SHALL appear after deassertion.

Structure
REQ-033 Shared package SHALL hold the state enum (IDLE, FLUSH), PC_WIDTH default and the instruction-size constant 4.
REQ-034 One sub-module, sat_counter32 (saturating enabled incrementer), SHALL be instantiated twice; no other hierarchy.

Verification
REQ-035 Reset mid-FLUSH (FLUSH_CYCLES=2): pulse rst_in low on flush's first cycle -> all outputs 0 at once, IDLE afterwards, counters 0.
REQ-036 Correct predict: pc=0x100, taken=1, target=0x200, pred_taken=1, pred_pc=0x200 -> next cycle upd_valid=1, upd_pc=0x100, upd_target=0x200, no redirect, br_count=1, mispred_count=0.
REQ-037 Direction mispredict: pc=0x104, taken=0, pred_taken=1 -> next cycle redirect_valid=1, redirect_pc=0x108, flush high 2 cycles, mispred_count=1.
REQ-038 Target mispredict plus wrong path: pc=0x10, taken=1, target=0x80, pred_pc=0x40 -> redirect_pc=0x80; a branch presented during flush yields no upd_valid and br_count unchanged.
REQ-039 Wrap and rdy stall: pc=0xFFFFFFFC not-taken, pred taken -> redirect_pc=0x0; rdy_in=0 for 3 cycles mid-flush -> flush length extends by 3 cycles, counters frozen.
